// File: rtl/tu_multi_bitslip_aligner_if.sv
`default_nettype none
// ============================================================================
//  Module   : tu_multi_bitslip_aligner_if
//  Purpose  : Control/config/data bundle between the register bank and the
//             multi-channel bitslip aligner.
//  Revision : 1.0  initial release
// ============================================================================
interface tu_multi_bitslip_aligner_if #(
    parameter int N_CH = 8,
    parameter int DW   = 64,
    parameter int SCW  = 16
);
    logic                 start;
    logic                 abort;
    logic                 cfg_mode;
    logic [DW-1:0]        cfg_pattern;
    logic [DW-1:0]        cfg_mask;
    logic [N_CH-1:0]      cfg_ch_en;
    logic [N_CH*DW-1:0]   data_in;
    logic [N_CH-1:0]      bitslip;
    logic                 busy;
    logic                 done;
    logic [N_CH-1:0]      success_mask;
    logic [N_CH-1:0]      fail_mask;
    logic [N_CH*SCW-1:0]  slip_cnt;
    logic [N_CH*DW-1:0]   dout;

    modport master (
        output start, abort, cfg_mode, cfg_pattern, cfg_mask, cfg_ch_en, data_in,
        input  bitslip, busy, done, success_mask, fail_mask, slip_cnt, dout
    );

    modport slave (
        input  start, abort, cfg_mode, cfg_pattern, cfg_mask, cfg_ch_en, data_in,
        output bitslip, busy, done, success_mask, fail_mask, slip_cnt, dout
    );
endinterface
`default_nettype wire

// File: rtl/tu_multi_bitslip_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : tu_multi_bitslip_aligner
//  Purpose  : N-channel ISERDES word-alignment hunter: slip, settle, check,
//             lock after LOCK_CNT consecutive matches or fail after MAX_SLIPS.
//  Revision : 1.0  initial release
// ============================================================================
module tu_multi_bitslip_aligner #(
    parameter int N_CH      = 8,
    parameter int DW        = 64,
    parameter int MAX_SLIPS = 2500,
    parameter int WAIT_CYC  = 4,
    parameter int LOCK_CNT  = 3,
    parameter int SCW       = 16
) (
    input  wire logic                 S_AXI_ACLK,
    input  wire logic                 S_AXI_ARESETN,
    tu_multi_bitslip_aligner_if.slave bus
);

    localparam int MCW = $clog2(LOCK_CNT + 1);
    localparam int WCW = $clog2(WAIT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SLIP   = 3'd2,
        S_WAIT   = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    logic            r_start_q;
    logic            r_busy;
    logic            r_done;
    logic            w_start_edge;
    logic [N_CH-1:0] w_active;

    // A start edge seen while a run is in progress is deliberately dropped.
    assign w_start_edge = bus.start & ~r_start_q & ~r_busy;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_start_q <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_start_q <= bus.start;
            if (bus.abort) begin
                r_busy <= 1'b0;
                r_done <= 1'b0;
            end else if (w_start_edge) begin
                r_busy <= |bus.cfg_ch_en;
                r_done <= ~|bus.cfg_ch_en;
            end else begin
                r_busy <= r_busy & |w_active;
                r_done <= r_busy & ~|w_active;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            state_t         r_state;
            logic [MCW-1:0] r_match_cnt;
            logic [WCW-1:0] r_wait_cnt;
            logic [SCW-1:0] r_slip_cnt;
            logic [DW-1:0]  r_dout;
            logic           r_success;
            logic           r_fail;
            logic           r_bitslip;
            logic [DW-1:0]  w_word;
            logic           w_match;

            assign w_word  = bus.data_in[k*DW +: DW];
            assign w_match = bus.cfg_mode ? ((w_word & bus.cfg_mask) == bus.cfg_pattern)
                                          : (|w_word);

            always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
                if (!S_AXI_ARESETN) begin
                    r_state     <= S_IDLE;
                    r_match_cnt <= '0;
                    r_wait_cnt  <= '0;
                    r_slip_cnt  <= '0;
                    r_dout      <= '0;
                    r_success   <= 1'b0;
                    r_fail      <= 1'b0;
                    r_bitslip   <= 1'b0;
                end else if (bus.abort) begin
                    r_state   <= S_IDLE;
                    r_bitslip <= 1'b0;
                end else if (w_start_edge) begin
                    r_state     <= bus.cfg_ch_en[k] ? S_CHECK : S_IDLE;
                    r_match_cnt <= '0;
                    r_wait_cnt  <= '0;
                    r_slip_cnt  <= '0;
                    r_dout      <= '0;
                    r_success   <= 1'b0;
                    r_fail      <= 1'b0;
                    r_bitslip   <= 1'b0;
                end else begin
                    case (r_state)
                        S_CHECK: begin
                            if (w_match) begin
                                if (r_match_cnt == MCW'(LOCK_CNT - 1)) begin
                                    r_state   <= S_LOCKED;
                                    r_dout    <= w_word;
                                    r_success <= 1'b1;
                                end else begin
                                    r_match_cnt <= r_match_cnt + 1'b1;
                                end
                            end else begin
                                r_match_cnt <= '0;
                                if (r_slip_cnt < SCW'(MAX_SLIPS)) begin
                                    r_state   <= S_SLIP;
                                    r_bitslip <= 1'b1;
                                end else begin
                                    r_state <= S_FAIL;
                                    r_fail  <= 1'b1;
                                end
                            end
                        end
                        S_SLIP: begin
                            r_bitslip  <= 1'b0;
                            r_slip_cnt <= r_slip_cnt + 1'b1;
                            r_wait_cnt <= '0;
                            r_state    <= S_WAIT;
                        end
                        S_WAIT: begin
                            if (r_wait_cnt == WCW'(WAIT_CYC - 1)) begin
                                r_state <= S_CHECK;
                            end else begin
                                r_wait_cnt <= r_wait_cnt + 1'b1;
                            end
                        end
                        default: r_bitslip <= 1'b0;
                    endcase
                end
            end

            assign w_active[k]                     = (r_state == S_CHECK) || (r_state == S_SLIP) ||
                                                     (r_state == S_WAIT);
            assign bus.bitslip[k]                  = r_bitslip;
            assign bus.success_mask[k]             = r_success;
            assign bus.fail_mask[k]                = r_fail;
            assign bus.slip_cnt[k*SCW +: SCW]      = r_slip_cnt;
            assign bus.dout[k*DW +: DW]            = r_dout;
        end
    endgenerate

endmodule
`default_nettype wire
